fifo_rd_ctrl: RTL

Read-side controller that sits directly downstream of the main FIFO. It drains the FIFO whenever data is present and the downstream stage is not almost full. It registers each popped word with a valid strobe and enforces a bounded burst length with a one-cycle gap. It counts pops and latches FIFO errors into a sticky error state.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_rd_pipe.sv | 41 ++++
 rtl/fifo_rd_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO word size default and read-controller state encoding
package fifo_pkg;

  localparam int FIFO_DATA_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ERROR  = 2'd3
  } rd_state_e;

  // burst_cnt only needs to hold 0..burst_len-1
  function automatic int burst_cnt_width(input int burst_len);
    return (burst_len < 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_rd_pipe.sv
// rtl/fifo_rd_pipe.sv - two-stage capture of popped FIFO words into data_out/valid_out
module fifo_rd_pipe
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] buffer_out,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out
);

  logic                 rd_d1_q, rd_d1_d;
  logic                 valid_q, valid_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  // buffer_out is valid the cycle after read, which is exactly when rd_d1_q is high
  always_comb begin
    rd_d1_d = read;
    valid_d = rd_d1_q;
    data_d  = rd_d1_q ? buffer_out : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      rd_d1_q <= rd_d1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read-side controller: burst-limited draining, pop counting, sticky error
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE   = FIFO_DATA_SIZE,
  parameter int BURST_LEN   = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic                   fifo_error,
  input  logic [DATA_SIZE-1:0]   buffer_out,
  input  logic                   dest_almost_full,
  output logic                   read,
  output logic [DATA_SIZE-1:0]   data_out,
  output logic                   valid_out,
  output logic [COUNT_WIDTH-1:0] pop_count,
  output logic                   idle,
  output logic                   error_out
);

  localparam int             BCW        = burst_cnt_width(BURST_LEN);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

  rd_state_e              state_q, state_d;
  logic [BCW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [COUNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic                   idle_q, idle_d;
  logic                   error_q, error_d;
  logic                   pop;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    pop_count_d = pop_count_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          pop = !fifo_empty && !dest_almost_full && !reset;
          if (pop) begin
            pop_count_d = pop_count_q + 1'b1;
            if (burst_cnt_q == BURST_LAST) begin
              burst_cnt_d = '0;
              state_d     = ST_PAUSE;
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        state_d = enable ? ST_ACTIVE : ST_IDLE;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    // A FIFO fault overrides every other transition and is only cleared by reset
    if (fifo_error) state_d = ST_ERROR;

    idle_d  = (state_d == ST_IDLE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      pop_count_q <= '0;
      idle_q      <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pop_count_q <= pop_count_d;
      idle_q      <= idle_d;
      error_q     <= error_d;
    end
  end

  fifo_rd_pipe #(
    .DATA_SIZE (DATA_SIZE)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .read       (pop),
    .buffer_out (buffer_out),
    .data_out   (data_out),
    .valid_out  (valid_out)
  );

  assign read      = pop;
  assign pop_count = pop_count_q;
  assign idle      = idle_q;
  assign error_out = error_q;

endmodule
